// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seg7 scan controller family:
// hex segment table, idle patterns and index-width helper.
package seg7_pkg;

   localparam int MAX_DIGITS = 8;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low {g,f,e,d,c,b,a}. The F glyph keeps the board's historical pattern.
   localparam logic [6:0] HEX_SEG [16] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000,  // 9
      7'b0001000,  // A
      7'b0000011,  // b
      7'b1000110,  // C
      7'b0100001,  // d
      7'b0000110,  // E
      7'b0001100   // F
   };

   // clog2 with a floor of 1 so single-entry counters still get a bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // All-anodes-off pattern for n digits, right-aligned in a MAX_DIGITS word.
   function automatic logic [MAX_DIGITS-1:0] an_off(input int n);
      logic [MAX_DIGITS-1:0] m;
      m = '0;
      for (int k = 0; k < MAX_DIGITS; k++) begin
         if (k < n) m[k] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment lookup.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed hex 7-segment scanner with PWM dimming, ghosting guard and
// frame-synchronous input snapshot. Optional SEG7_LEADING_ZERO_BLANK_EN adds leading-zero suppression.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 400000,
   parameter int BLANK_CYC  = 16,
   parameter int DIM_BITS   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   input  logic [NUM_DIGITS-1:0]   blank_i,
   input  logic [DIM_BITS-1:0]     bright_i,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_o
);

   localparam int IW = idx_width(NUM_DIGITS);
   localparam int PW = idx_width(SCAN_DIV);

   localparam logic [IW-1:0]         IDX_LAST    = IW'(NUM_DIGITS - 1);
   localparam logic [PW-1:0]         PRESC_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0]         GUARD       = PW'(BLANK_CYC);
   localparam logic [MAX_DIGITS-1:0] AN_ALL      = an_off(NUM_DIGITS);
   localparam logic [NUM_DIGITS-1:0] AN_IDLE     = AN_ALL[NUM_DIGITS-1:0];
   localparam logic [DIM_BITS-1:0]   BRIGHT_FULL = '1;

   // scan state
   logic [PW-1:0]           presc;
   logic [IW-1:0]           idx;
   logic [DIM_BITS-1:0]     pwm_cnt;
   logic                    first_q;

   // frame shadow registers
   logic [4*NUM_DIGITS-1:0] sh_dig;
   logic [NUM_DIGITS-1:0]   sh_dp;
   logic [NUM_DIGITS-1:0]   sh_blank;

   // next-state and display path
   logic                    presc_wrap;
   logic                    frame_wrap;
   logic                    snap;
   logic [PW-1:0]           presc_nxt;
   logic [IW-1:0]           idx_nxt;
   logic [NUM_DIGITS-1:0]   blank_snap;
   logic [4*NUM_DIGITS-1:0] eff_dig;
   logic [NUM_DIGITS-1:0]   eff_dp;
   logic [NUM_DIGITS-1:0]   eff_blank;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_blank;
   logic [NUM_DIGITS-1:0]   an_sel;
   logic                    pwm_on;
   logic                    lit;
   logic [6:0]              seg_dec;
   logic [NUM_DIGITS-1:0]   an_nxt;
   logic [6:0]              seg_nxt;
   logic                    dp_nxt;

   always_comb begin
      presc_wrap = (presc == PRESC_LAST);
      frame_wrap = presc_wrap && (idx == IDX_LAST);
      snap       = first_q || frame_wrap;
      presc_nxt  = presc_wrap ? '0 : presc + 1'b1;
      idx_nxt    = idx;
      if (presc_wrap) begin
         idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
   end

   // Blank mask as it will be latched at the next snapshot.
   always_comb begin
      blank_snap = blank_i;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      begin : g_lz
         logic lz_run;
         lz_run = 1'b1;
         for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if ((digits_i[4*k +: 4] != 4'h0) || dp_i[k]) lz_run = 1'b0;
            if (lz_run) blank_snap[k] = 1'b1;
         end
      end
`endif
   end

   // The very first cycle after reset shows the values being captured right now.
   always_comb begin
      eff_dig   = first_q ? digits_i   : sh_dig;
      eff_dp    = first_q ? dp_i       : sh_dp;
      eff_blank = first_q ? blank_snap : sh_blank;
   end

   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b1;
      an_sel    = AN_IDLE;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == IW'(k)) begin
            cur_nib   = eff_dig[4*k +: 4];
            cur_dp    = eff_dp[k];
            cur_blank = eff_blank[k];
            an_sel[k] = 1'b0;
         end
      end
   end

   seg7_hex_decode u_dec (
      .nibble (cur_nib),
      .seg    (seg_dec)
   );

   always_comb begin
      pwm_on  = (pwm_cnt < bright_i) || (bright_i == BRIGHT_FULL);
      lit     = (presc >= GUARD) && !cur_blank && pwm_on;
      an_nxt  = lit ? an_sel  : AN_IDLE;
      seg_nxt = lit ? seg_dec : SEG_OFF;
      dp_nxt  = lit ? ~cur_dp : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc    <= '0;
         idx      <= '0;
         pwm_cnt  <= '0;
         first_q  <= 1'b1;
         sh_dig   <= '0;
         sh_dp    <= '0;
         sh_blank <= '0;
         an       <= AN_IDLE;
         seg      <= SEG_OFF;
         dp       <= 1'b1;
         frame_o  <= 1'b0;
      end else begin
         presc   <= presc_nxt;
         idx     <= idx_nxt;
         pwm_cnt <= pwm_cnt + 1'b1;
         first_q <= 1'b0;
         if (snap) begin
            sh_dig   <= digits_i;
            sh_dp    <= dp_i;
            sh_blank <= blank_snap;
         end
         an      <= an_nxt;
         seg     <= seg_nxt;
         dp      <= dp_nxt;
         frame_o <= frame_wrap;
      end
   end

endmodule
